// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin write controller sharing a four-register bank between two requesters
module reg_bank_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req0,
    input  logic [1:0]         addr0,
    input  logic [WIDTH-1:0]   d0,
    input  logic               req1,
    input  logic [1:0]         addr1,
    input  logic [WIDTH-1:0]   d1,
    output logic               ack0,
    output logic               ack1,
    output logic [1:0]         gnt,
    output logic               busy,
    input  logic [1:0]         rd_addr,
    output logic [WIDTH-1:0]   rd_data,
    output logic [4*WIDTH-1:0] q_all
);
    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;
    state_t             state, state_n;
    logic [WIDTH-1:0]   regs [4];
    logic               last, last_n, win, win_n, pick, ack0_n, ack1_n;
    logic [1:0]         waddr, waddr_n, gnt_n;
    logic [WIDTH-1:0]   wdata, wdata_n;
    assign pick    = (req0 && req1) ? ~last : req1;
    assign busy    = state != IDLE;
    assign rd_data = regs[rd_addr];
    assign q_all   = {regs[3], regs[2], regs[1], regs[0]};
    // next state and next registered outputs; the winner's addr/data are captured at grant time
    always_comb begin
        state_n = state;
        last_n  = last;
        win_n   = win;
        waddr_n = waddr;
        wdata_n = wdata;
        gnt_n   = gnt;
        ack0_n  = ack0;
        ack1_n  = ack1;
        case (state)
            IDLE: if (req0 || req1) begin
                win_n   = pick;
                waddr_n = pick ? addr1 : addr0;
                wdata_n = pick ? d1 : d0;
                gnt_n   = pick ? 2'b10 : 2'b01;
                state_n = WRITE;
            end
            WRITE: begin
                ack0_n  = ~win;
                ack1_n  = win;
                last_n  = win;
                state_n = ACK;
            end
            ACK: begin
                ack0_n  = 1'b0;
                ack1_n  = 1'b0;
                gnt_n   = 2'b00;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // controller state; last starts at 1 so requester 0 wins the first contention
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            last  <= 1'b1;
            win   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            gnt   <= 2'b00;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
        end else begin
            state <= state_n;
            last  <= last_n;
            win   <= win_n;
            waddr <= waddr_n;
            wdata <= wdata_n;
            gnt   <= gnt_n;
            ack0  <= ack0_n;
            ack1  <= ack1_n;
        end
    end
    // register bank, loaded only in WRITE with the latched address and data
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (state == WRITE) begin
            regs[waddr] <= wdata;
        end
    end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: scoreboard bench for the arbitrated register bank
module tb_reg_bank_arbiter;
    logic        clk = 0, clr = 0;
    logic        req0 = 0, req1 = 0;
    logic [1:0]  addr0 = 0, addr1 = 0, rd_addr = 0;
    logic [7:0]  d0 = 0, d1 = 0;
    logic        ack0, ack1, busy;
    logic [1:0]  gnt;
    logic [7:0]  rd_data;
    logic [31:0] q_all;
    int          n_chk = 0, n_pass = 0, cyc = 0;

    typedef struct {
        int         who;
        logic [1:0] addr;
        logic [7:0] data;
        int         at;
    } exp_t;
    exp_t sb[$];

    reg_bank_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .clr(clr),
        .req0(req0), .addr0(addr0), .d0(d0),
        .req1(req1), .addr1(addr1), .d1(d1),
        .ack0(ack0), .ack1(ack1), .gnt(gnt), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data), .q_all(q_all)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push(input int who, input logic [1:0] a, input logic [7:0] d, input int lat);
        exp_t e;
        e.who = who; e.addr = a; e.data = d; e.at = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int who, input bit drop);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (who != 0) ? ack1 : ack0;
        end
        check($sformatf("ack%0d_seen", who), {31'd0, seen}, 1);
        if (seen && drop) begin
            if (who != 0) req1 = 0;
            else req0 = 0;
        end
    endtask

    // scoreboard consumer plus per-cycle grant/ack invariants
    always @(negedge clk) begin
        if (clr) begin
            check("gnt_onehot", {31'd0, $countones(gnt) <= 1}, 1);
            check("ack_excl", {31'd0, !(ack0 && ack1)}, 1);
            if (ack0 || ack1) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", {30'd0, ack1, ack0}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_who", {31'd0, ack1}, e.who);
                    check("ack_cycle", cyc, e.at);
                    check("ack_gnt", {30'd0, gnt}, (e.who != 0) ? 2 : 1);
                    check("reg_data", {24'd0, q_all[int'(e.addr)*8 +: 8]}, {24'd0, e.data});
                end
            end
        end
    end

    initial begin
        #1;
        check("rst_q_all", q_all, 0);
        check("rst_ctl", {27'd0, gnt, busy, ack1, ack0}, 0);
        @(negedge clk) clr = 1;
        // data stability: d0 changes while WRITE is in progress
        @(negedge clk);
        req0 = 1; addr0 = 1; d0 = 8'h01; push(0, 1, 8'h01, 2);
        @(negedge clk);
        check("write_gnt_busy", {29'd0, gnt, busy}, 3'b011);
        d0 = 8'hFF;
        wait_ack(0, 1);
        rd_addr = 1; #1;
        check("stable_rd", {24'd0, rd_data}, 8'h01);
        // same-address collision with last = 0: req1 first, req0 last
        @(negedge clk);
        req0 = 1; addr0 = 3; d0 = 8'h11;
        req1 = 1; addr1 = 3; d1 = 8'h22;
        push(1, 3, 8'h22, 2); push(0, 3, 8'h11, 5);
        wait_ack(1, 1);
        wait_ack(0, 1);
        check("collide_reg3", {24'd0, q_all[31:24]}, 8'h11);
        // lone req1 write, leaving last = 1
        @(negedge clk);
        req1 = 1; addr1 = 1; d1 = 8'h5A; push(1, 1, 8'h5A, 2);
        wait_ack(1, 1);
        // contention: req0 served first, ack1 three cycles after ack0
        @(negedge clk);
        req0 = 1; addr0 = 0; d0 = 8'hAA;
        req1 = 1; addr1 = 1; d1 = 8'h0F;
        push(0, 0, 8'hAA, 2); push(1, 1, 8'h0F, 5);
        wait_ack(0, 1);
        wait_ack(1, 1);
        check("contend_regs", {16'd0, q_all[15:0]}, 32'h0000_0FAA);
        // fairness: both held for four transactions
        @(negedge clk);
        req0 = 1; addr0 = 2; d0 = 8'h33;
        req1 = 1; addr1 = 3; d1 = 8'h44;
        push(0, 2, 8'h33, 2); push(1, 3, 8'h44, 5);
        push(0, 2, 8'h33, 8); push(1, 3, 8'h44, 11);
        wait_ack(0, 0);
        wait_ack(1, 0);
        wait_ack(0, 1);
        wait_ack(1, 1);
        check("fair_q_all", q_all, 32'h4433_0FAA);
        // reset during WRITE
        @(negedge clk);
        req0 = 1; addr0 = 0; d0 = 8'h77;
        @(negedge clk);
        check("pre_rst_state", {29'd0, gnt, busy}, 3'b011);
        #2 clr = 0;
        #1;
        check("async_q_all", q_all, 0);
        check("async_ctl", {27'd0, gnt, busy, ack1, ack0}, 0);
        for (int i = 0; i < 4; i++) begin
            rd_addr = i[1:0]; #1;
            check($sformatf("rst_rd%0d", i), {24'd0, rd_data}, 0);
        end
        req0 = 0;
        @(negedge clk);
        check("rst_no_ack", {30'd0, ack1, ack0}, 0);
        clr = 1;
        // first write after release
        @(negedge clk);
        req0 = 1; addr0 = 2; d0 = 8'h55; push(0, 2, 8'h55, 2);
        wait_ack(0, 1);
        rd_addr = 2; #1;
        check("post_rst_rd", {24'd0, rd_data}, 8'h55);
        repeat (4) @(negedge clk);
        check("final_q_all", q_all, 32'h0055_0000);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
